anabellek_denetleyici: RTL

ANABELLEK_DENETLEYICI -- requirements
Module: anabellek_denetleyici

---
 rtl/anabellek_denetleyici_if.sv | 31 +++
 rtl/anabellek_denetleyici.sv | 102 ++++++++++
 2 files changed

// File: rtl/anabellek_denetleyici_if.sv
// Cache-side block request and main-memory beat bus of the main-memory block controller.
// slave is the controller's view; master is the side that drives requests and memory responses.
interface anabellek_denetleyici_if;
  logic         istek_i;
  logic         yaz_i;
  logic         oku_i;
  logic [31:0]  adres_i;
  logic [127:0] kirli_obek_i;
  logic         musait_o;
  logic         hazir_o;
  logic [127:0] okunan_obek_o;
  logic         hata_o;
  logic         bellek_gecerli_o;
  logic         bellek_yaz_o;
  logic [31:0]  bellek_adres_o;
  logic [31:0]  bellek_veri_o;
  logic         bellek_hazir_i;
  logic [31:0]  bellek_veri_i;

  modport slave (
    input  istek_i, yaz_i, oku_i, adres_i, kirli_obek_i, bellek_hazir_i, bellek_veri_i,
    output musait_o, hazir_o, okunan_obek_o, hata_o,
    output bellek_gecerli_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o
  );

  modport master (
    output istek_i, yaz_i, oku_i, adres_i, kirli_obek_i, bellek_hazir_i, bellek_veri_i,
    input  musait_o, hazir_o, okunan_obek_o, hata_o,
    input  bellek_gecerli_o, bellek_yaz_o, bellek_adres_o, bellek_veri_o
  );
endinterface

// File: rtl/anabellek_denetleyici.sv
// Main-memory block controller: turns one cache block request into four 32-bit memory beats
// (write-back or fill), with an optional per-beat wait timeout that aborts the burst.
module anabellek_denetleyici #(
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  anabellek_denetleyici_if.slave        bus
);
  localparam int BW = (ZAMAN_ASIMI > 1) ? $clog2(ZAMAN_ASIMI) : 1;
  localparam logic [BW-1:0] ESIK = BW'((ZAMAN_ASIMI > 0) ? ZAMAN_ASIMI - 1 : 0);

  typedef enum logic [1:0] {BOSTA, YAZ, OKU, TAMAM} durum_t;

  durum_t             durum_reg, durum_next;
  logic [1:0]         sayac_reg, sayac_next;
  logic [BW-1:0]      bekle_reg, bekle_next;
  logic [31:0]        taban_reg, taban_next;
  logic [3:0][31:0]   obek_reg, obek_next;
  logic [3:0][31:0]   dolgu_reg, dolgu_next;
  logic               hata_reg, hata_next;
  logic               vurus_aktif;
  logic               okuma_gecerli;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      durum_reg <= BOSTA;
      sayac_reg <= '0;
      bekle_reg <= '0;
      taban_reg <= '0;
      obek_reg  <= '0;
      dolgu_reg <= '0;
      hata_reg  <= 1'b0;
    end else begin
      durum_reg <= durum_next;
      sayac_reg <= sayac_next;
      bekle_reg <= bekle_next;
      taban_reg <= taban_next;
      obek_reg  <= obek_next;
      dolgu_reg <= dolgu_next;
      hata_reg  <= hata_next;
    end
  end

  always_comb begin
    durum_next = durum_reg;
    sayac_next = sayac_reg;
    bekle_next = bekle_reg;
    taban_next = taban_reg;
    obek_next  = obek_reg;
    dolgu_next = dolgu_reg;
    hata_next  = hata_reg;
    case (durum_reg)
      BOSTA, TAMAM: begin
        durum_next = BOSTA;
        // A request with neither direction set is dropped without touching the latches.
        if (bus.istek_i && (bus.yaz_i || bus.oku_i)) begin
          durum_next = bus.yaz_i ? YAZ : OKU;
          taban_next = bus.adres_i & 32'hFFFF_FFF0;
          obek_next  = bus.kirli_obek_i;
          dolgu_next = '0;
          sayac_next = 2'd0;
          bekle_next = '0;
          hata_next  = 1'b0;
        end
      end
      default: begin
        if (bus.bellek_hazir_i) begin
          if (durum_reg == OKU) dolgu_next[sayac_reg] = bus.bellek_veri_i;
          sayac_next = sayac_reg + 2'd1;
          bekle_next = '0;
          if (sayac_reg == 2'd3) durum_next = TAMAM;
        end else if (ZAMAN_ASIMI > 0) begin
          if (bekle_reg == ESIK) begin
            durum_next = TAMAM;
            hata_next  = 1'b1;
          end else begin
            bekle_next = bekle_reg + 1'b1;
          end
        end
      end
    endcase
  end

  assign vurus_aktif   = (durum_reg == YAZ) || (durum_reg == OKU);
  // Aborted or write bursts complete with an all-zero block.
  assign okuma_gecerli = (durum_reg == TAMAM) && !hata_reg;

  assign bus.musait_o         = (durum_reg == BOSTA) || (durum_reg == TAMAM);
  assign bus.hazir_o          = (durum_reg == TAMAM);
  assign bus.hata_o           = (durum_reg == TAMAM) && hata_reg;
  assign bus.bellek_gecerli_o = vurus_aktif;
  assign bus.bellek_yaz_o     = (durum_reg == YAZ);
  assign bus.bellek_adres_o   = vurus_aktif ? (taban_reg + {28'd0, sayac_reg, 2'b00}) : 32'd0;
  assign bus.bellek_veri_o    = vurus_aktif ? obek_reg[sayac_reg] : 32'd0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_okunan
      assign bus.okunan_obek_o[32*gi +: 32] = okuma_gecerli ? dolgu_reg[gi] : 32'd0;
    end
  endgenerate
endmodule
